// File: rtl/cache_miss_ctrl_if.sv
// cache_miss_ctrl_if: cache-side miss request and memory-side request/ack bundle
// for the miss/refill sequencer.
interface cache_miss_ctrl_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cache_miss;
    logic          miss_is_wr;
    logic [AW-1:0] miss_addr;
    logic          victim_dirty;
    logic [AW-1:0] victim_addr;
    logic [DW-1:0] victim_data;
    logic          stall;
    logic          fill_valid;
    logic [DW-1:0] fill_data;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    modport slave (
        input  cache_miss, miss_is_wr, miss_addr, victim_dirty, victim_addr, victim_data,
        input  mem_rdata, mem_ack,
        output stall, fill_valid, fill_data, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cache_miss, miss_is_wr, miss_addr, victim_dirty, victim_addr, victim_data,
        output mem_rdata, mem_ack,
        input  stall, fill_valid, fill_data, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_miss_ctrl.sv
// cache_miss_ctrl: miss/refill sequencer -- dirty writeback, word fetch, fill pulse,
// memory-wait timeout with sticky error and saturating miss/writeback counters.
module cache_miss_ctrl #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64,
    parameter int CW      = 16
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    cache_miss_ctrl_if.slave bus,
    output logic             bus_err_o,
    output logic [CW-1:0]    miss_cnt_o,
    output logic [CW-1:0]    wb_cnt_o
);
    localparam int            TW        = $clog2(TIMEOUT);
    localparam logic [TW-1:0] WAIT_MAX  = TW'(TIMEOUT - 1);
    localparam logic [AW-1:0] WORD_MASK = ~AW'(3);

    typedef enum logic [1:0] {IDLE, WB, RD, FILL} state_t;

    state_t        state_q;
    logic          is_wr_q;
    logic [AW-1:0] miss_addr_q;
    logic [TW-1:0] wait_q;
    logic          mem_req_q, mem_we_q, fill_valid_q, bus_err_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q, fill_data_q;
    logic [CW-1:0] miss_cnt_q, wb_cnt_q;

    assign bus.stall      = (state_q != IDLE) || bus.cache_miss;
    assign bus.fill_valid = fill_valid_q;
    assign bus.fill_data  = fill_data_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus_err_o      = bus_err_q;
    assign miss_cnt_o     = miss_cnt_q;
    assign wb_cnt_o       = wb_cnt_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= IDLE;
            is_wr_q      <= 1'b0;
            miss_addr_q  <= '0;
            wait_q       <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            fill_valid_q <= 1'b0;
            fill_data_q  <= '0;
            bus_err_q    <= 1'b0;
            miss_cnt_q   <= '0;
            wb_cnt_q     <= '0;
        end else begin
            fill_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.cache_miss) begin
                    is_wr_q     <= bus.miss_is_wr;
                    miss_addr_q <= bus.miss_addr & WORD_MASK;
                    mem_wdata_q <= bus.victim_data;
                    miss_cnt_q  <= miss_cnt_q + CW'(~&miss_cnt_q);
                    wait_q      <= '0;
                    if (bus.victim_dirty) begin
                        state_q    <= WB;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= bus.victim_addr & WORD_MASK;
                    end else if (!bus.miss_is_wr) begin
                        state_q    <= RD;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= bus.miss_addr & WORD_MASK;
                    end else begin
                        state_q <= FILL;
                    end
                end
                WB, RD: if (bus.mem_ack) begin
                    wait_q <= '0;
                    if (state_q == WB) begin
                        // a read miss chains straight into its fetch without dropping mem_req
                        wb_cnt_q   <= wb_cnt_q + CW'(~&wb_cnt_q);
                        state_q    <= is_wr_q ? FILL : RD;
                        mem_req_q  <= !is_wr_q;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= miss_addr_q;
                    end else begin
                        fill_data_q  <= bus.mem_rdata;
                        fill_valid_q <= 1'b1;
                        state_q      <= FILL;
                        mem_req_q    <= 1'b0;
                    end
                end else if (wait_q == WAIT_MAX) begin
                    mem_req_q <= 1'b0;
                    bus_err_q <= 1'b1;
                    state_q   <= FILL;
                end else begin
                    wait_q <= wait_q + TW'(1);
                end
                FILL: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_miss_ctrl.sv
// tb_cache_miss_ctrl: scoreboard bench -- expected memory transactions and fill words
// are queued when a miss is driven and popped when the DUT acks/fills.
module tb_cache_miss_ctrl;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 8;
    localparam int CW      = 8;
    localparam int MAXC    = (1 << CW) - 1;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } txn_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          bus_err;
    logic [CW-1:0] miss_cnt, wb_cnt;

    txn_t          exp_q[$];
    logic [DW-1:0] fill_q[$];

    int            errors = 0, checks = 0;
    int            lat = 0, mcnt = 0, stall_cnt = 0, req_cnt = 0;
    int            exp_miss = 0, exp_wb = 0;
    logic          exp_berr = 1'b0;
    bit            no_ack = 1'b0, force_ack = 1'b0;
    logic [DW-1:0] rdata_cfg = '0;

    cache_miss_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    cache_miss_ctrl #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .clk_i      (clk),
        .reset_ni   (reset_n),
        .bus        (bus),
        .bus_err_o  (bus_err),
        .miss_cnt_o (miss_cnt),
        .wb_cnt_o   (wb_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        return v > MAXC ? MAXC : v;
    endfunction

    // memory responder and scoreboard monitor share one negedge process so ack and checks agree
    initial begin
        logic ack;
        txn_t t;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            ack = force_ack || (bus.mem_req && !no_ack && mcnt == lat);
            mcnt = (bus.mem_req && !ack) ? mcnt + 1 : 0;
            bus.mem_ack   = ack;
            bus.mem_rdata = ack ? rdata_cfg : ~rdata_cfg;
            if (bus.stall) stall_cnt++;
            if (bus.mem_req) req_cnt++;
            if (bus.mem_req && ack) begin
                chk("mem_expected", 64'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    t = exp_q.pop_front();
                    chk("mem_we", bus.mem_we, t.we);
                    chk("mem_addr", bus.mem_addr, t.a);
                    if (t.we) chk("mem_wdata", bus.mem_wdata, t.d);
                end
            end
            if (bus.fill_valid) begin
                chk("fill_expected", 64'(fill_q.size() > 0), 1);
                if (fill_q.size() > 0) chk("fill_data", bus.fill_data, fill_q.pop_front());
            end
        end
    end

    task automatic run_miss(input logic wr, input logic dirty, input logic [AW-1:0] a,
                            input logic [AW-1:0] va, input logic [DW-1:0] vd,
                            input int exp_stall, input int exp_req, input string tag);
        txn_t t;
        @(posedge clk);
        #1;
        if (dirty) begin
            t.we = 1'b1; t.a = va & ~32'h3; t.d = vd;
            exp_q.push_back(t);
            exp_wb = sat(exp_wb + 1);
        end
        if (!wr && !no_ack) begin
            t.we = 1'b0; t.a = a & ~32'h3; t.d = '0;
            exp_q.push_back(t);
            fill_q.push_back(rdata_cfg);
        end
        exp_miss = sat(exp_miss + 1);
        stall_cnt = 0;
        req_cnt   = 0;
        bus.cache_miss   = 1'b1;
        bus.miss_is_wr   = wr;
        bus.victim_dirty = dirty;
        bus.miss_addr    = a;
        bus.victim_addr  = va;
        bus.victim_data  = vd;
        @(posedge clk);
        #1;
        bus.cache_miss   = 1'b0;
        bus.miss_is_wr   = 1'($urandom);
        bus.victim_dirty = 1'($urandom);
        bus.miss_addr    = $urandom;
        bus.victim_addr  = $urandom;
        bus.victim_data  = $urandom;
        for (int i = 0; i < 100 && bus.stall; i++) @(negedge clk);
        chk({tag, "_idle"}, bus.stall, 0);
        chk({tag, "_stall"}, stall_cnt, exp_stall);
        chk({tag, "_req"}, req_cnt, exp_req);
        chk({tag, "_drained"}, exp_q.size() + fill_q.size(), 0);
        chk({tag, "_miss_cnt"}, miss_cnt, exp_miss);
        chk({tag, "_wb_cnt"}, wb_cnt, exp_wb);
        chk({tag, "_bus_err"}, bus_err, exp_berr);
    endtask

    initial begin
        bus.cache_miss   = 1'b0;
        bus.miss_is_wr   = 1'b0;
        bus.victim_dirty = 1'b0;
        bus.miss_addr    = '0;
        bus.victim_addr  = '0;
        bus.victim_data  = '0;
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", bus.stall, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_fill_valid", bus.fill_valid, 0);
        chk("rst_fill_data", bus.fill_data, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_miss_cnt", miss_cnt, 0);
        chk("rst_wb_cnt", wb_cnt, 0);
        reset_n = 1'b1;

        lat = 3; rdata_cfg = 32'hDEADBEEF;
        run_miss(1'b0, 1'b0, 32'h1004, 32'h0, 32'h0, 6, 4, "clean_rd");
        lat = 0; rdata_cfg = 32'hCAFEF00D;
        run_miss(1'b0, 1'b1, 32'h300C, 32'h2008, 32'h12345678, 4, 2, "dirty_rd");
        rdata_cfg = 32'h13579BDF;
        run_miss(1'b0, 1'b0, 32'h4007, 32'h0, 32'h0, 3, 1, "unaligned_rd");
        lat = 1;
        run_miss(1'b1, 1'b1, 32'h6000, 32'h5003, 32'hA5A5A5A5, 4, 2, "dirty_wr");
        run_miss(1'b1, 1'b0, 32'h7000, 32'h0, 32'h0, 2, 0, "clean_wr");

        no_ack = 1'b1; exp_berr = 1'b1;
        run_miss(1'b0, 1'b0, 32'h8000, 32'h0, 32'h0, 10, 8, "timeout");
        force_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1 force_ack = 1'b0;
        chk("late_ack_miss_cnt", miss_cnt, exp_miss);
        chk("late_ack_wb_cnt", wb_cnt, exp_wb);
        chk("late_ack_stall", bus.stall, 0);
        no_ack = 1'b0; lat = 0; rdata_cfg = 32'h0BADF00D;
        run_miss(1'b0, 1'b0, 32'h9000, 32'h0, 32'h0, 3, 1, "after_timeout");

        no_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.cache_miss = 1'b1; bus.miss_is_wr = 1'b0; bus.victim_dirty = 1'b0; bus.miss_addr = 32'hA000;
        @(posedge clk);
        #1 bus.cache_miss = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("pre_rst_mem_req", bus.mem_req, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("async_rst_mem_req", bus.mem_req, 0);
        chk("async_rst_stall", bus.stall, 0);
        chk("async_rst_miss_cnt", miss_cnt, 0);
        chk("async_rst_wb_cnt", wb_cnt, 0);
        chk("async_rst_bus_err", bus_err, 0);
        exp_miss = 0; exp_wb = 0; exp_berr = 1'b0; no_ack = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        rdata_cfg = 32'h2468ACE0;
        run_miss(1'b0, 1'b1, 32'hB004, 32'hC000, 32'h55AA55AA, 4, 2, "post_rst");

        for (int i = 0; i < MAXC + 2; i++)
            run_miss(1'b1, 1'b0, 32'hD000, 32'h0, 32'h0, 2, 0, "sat");
        chk("miss_cnt_saturated", miss_cnt, MAXC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
